// File: rtl/pmem_responder.sv
// -----------------------------------------------------------------------------
// pmem_responder
//   Behavioural line memory that answers a held pmem_read / pmem_write request
//   a fixed LATENCY cycles after acceptance with a one-cycle pmem_resp strobe.
//   Stores 2^IDX_BITS lines of 256 bits; the line index is taken from
//   pmem_address[5 +: IDX_BITS]. All other address bits are ignored, so
//   out-of-range addresses alias onto stored lines.
//
// Parameters
//   IDX_BITS  log2 of the number of stored lines (default 8)
//   LATENCY   cycles from acceptance to pmem_resp, 1..15 (default 4)
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous active-high reset (array contents are kept)
//   pmem_read     line read request, held until pmem_resp
//   pmem_write    line write request, held until pmem_resp (wins over read)
//   pmem_address  byte address of the line
//   pmem_wdata    write line data
//   pmem_rdata    read line data, valid in the response cycle and held
//   pmem_resp     one-cycle completion strobe
//   pmem_err      sticky protocol-error flag
//
// Build option
//   PMEM_PROTOCOL_CHECK_EN  when defined, pmem_err latches on simultaneous
//                           read+write or on a request change while busy;
//                           otherwise pmem_err is tied to 0.
// -----------------------------------------------------------------------------
module pmem_responder #(
    parameter int IDX_BITS = 8,
    parameter int LATENCY  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    output logic [255:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         pmem_err
);

    localparam int   LINES   = 1 << IDX_BITS;
    localparam logic LAT_ONE = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [3:0]            cnt_r;
    logic [3:0]            cnt_nxt_s;
    logic [IDX_BITS-1:0]   idx_r;
    logic [IDX_BITS-1:0]   req_idx_s;
    logic [IDX_BITS-1:0]   rd_idx_s;
    logic [1:0]            op_r;        // {read, write}; write already given priority
    logic [255:0]          wdata_r;
    logic [255:0]          rdata_r;
    logic                  resp_r;
    logic                  accept_s;
    logic                  load_rdata_s;
    logic [255:0]          mem_r [LINES];
    logic                  addr_unused_s;

    assign req_idx_s     = pmem_address[5 +: IDX_BITS];
    assign addr_unused_s = ^{pmem_address[31:5+IDX_BITS], pmem_address[4:0]};

    // Next-state, counter and read-capture decisions
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        accept_s     = 1'b0;
        rd_idx_s     = idx_r;
        load_rdata_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pmem_read || pmem_write) begin
                    accept_s = 1'b1;
                    rd_idx_s = req_idx_s;
                    if (LAT_ONE) begin
                        // Response follows directly: fetch read data now.
                        state_nxt_s  = ST_RESP;
                        cnt_nxt_s    = 4'd0;
                        load_rdata_s = pmem_read & ~pmem_write;
                    end else begin
                        state_nxt_s = ST_BUSY;
                        cnt_nxt_s   = 4'(LATENCY - 1);
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 4'd1) begin
                    state_nxt_s  = ST_RESP;
                    cnt_nxt_s    = 4'd0;
                    load_rdata_s = op_r[1];
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Control state, request capture and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= '0;
            op_r    <= 2'b00;
            wdata_r <= 256'd0;
            rdata_r <= 256'd0;
            resp_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            resp_r  <= (state_nxt_s == ST_RESP);
            if (accept_s) begin
                idx_r   <= req_idx_s;
                op_r    <= {pmem_read & ~pmem_write, pmem_write};
                wdata_r <= pmem_wdata;
            end else begin
                idx_r   <= idx_r;
            end
            if (load_rdata_s) begin
                rdata_r <= mem_r[rd_idx_s];
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Array write: commits only at the edge that ends the response cycle
    always_ff @(posedge clk) begin
        if (!rst && (state_r == ST_RESP) && op_r[0]) begin
            mem_r[idx_r] <= wdata_r;
        end
    end

    assign pmem_rdata = rdata_r;
    assign pmem_resp  = resp_r;

`ifdef PMEM_PROTOCOL_CHECK_EN
    logic err_r;

    // Sticky protocol checker: dual request or request change while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if ((pmem_read && pmem_write) ||
                     ((state_r == ST_BUSY) && ({pmem_read, pmem_write} != op_r))) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign pmem_err = err_r;
`else
    assign pmem_err = 1'b0;
`endif

endmodule

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 SHALL have parameter IDX_BITS, default 8, meaning log2 of the number of 256-bit lines stored.
REQ-002 SHALL have parameter LATENCY, default 4, legal range 1..15, meaning cycles from request acceptance to pmem_resp.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pmem_read  input  1  line read request, held by the initiator until pmem_resp.
REQ-006 SHALL have port pmem_write  input  1  line write request, held by the initiator until pmem_resp.
REQ-007 SHALL have port pmem_address  input  32  byte address of the line.
REQ-008 SHALL have port pmem_wdata  input  256  write line data.
REQ-009 SHALL have port pmem_rdata  output  256  read line data.
REQ-010 SHALL have port pmem_resp  output  1  one-cycle completion strobe.
REQ-011 SHALL have port pmem_err  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-012 SHALL store 2^IDX_BITS lines; line index = pmem_address[5+IDX_BITS-1:5]; bits [4:0] and bits above the index are ignored, so out-of-range addresses alias.
REQ-013 SHALL implement FSM IDLE, BUSY, RESP.
REQ-014 IDLE: request seen in cycle t (pmem_read or pmem_write high) -> capture index, opcode and wdata at edge ending t; next state BUSY if LATENCY>1, else RESP.
REQ-015 BUSY: a 4-bit down-counter loaded with LATENCY-1 at acceptance; on reaching 1, next state RESP.
REQ-016 pmem_resp SHALL be high in exactly cycle t+LATENCY and low in all other cycles.
REQ-017 RESP: next state IDLE unconditionally; a request still high in cycle t+LATENCY+1 is accepted as a new request.
REQ-018 Write SHALL commit the captured wdata to the array at the edge ending the RESP cycle; no earlier array modification.
REQ-019 Read SHALL drive the stored line on pmem_rdata during the RESP cycle; pmem_rdata SHALL hold that value until the next read's RESP.
REQ-020 Write completion SHALL leave pmem_rdata unchanged.
REQ-021 Read and write both high at acceptance: write SHALL win; read ignored.
REQ-022 Changes to inputs during BUSY/RESP SHALL NOT affect the operation in flight (captured values used).
REQ-023 Back-to-back: a read of the line written by the preceding write SHALL return the new data.

Reset
REQ-024 rst high at an edge SHALL force state IDLE, counter 0, pmem_resp 0, pmem_rdata 0, pmem_err 0.
REQ-025 Reset during BUSY or RESP SHALL abort the operation: no pmem_resp, no array write.
REQ-026 Array contents SHALL NOT be reset.
REQ-027 A request high in the cycle rst deasserts SHALL be accepted normally in the following cycle.

Configuration
REQ-028 Macro PMEM_PROTOCOL_CHECK_EN defined: pmem_err SHALL set (sticky until rst) at any edge where (a) pmem_read and pmem_write both high, or (b) in BUSY the opcode inputs differ from the captured opcode (dropped/changed request).
REQ-029 Macro PMEM_PROTOCOL_CHECK_EN undefined: pmem_err SHALL be constant 0 and no checker logic synthesized; all other behaviour identical.

Verification
REQ-030 Reset, then write 0x..A5A5 (all 32 bytes 0xA5) to address 0x0000_0040 with LATENCY=4 -> pmem_resp high exactly 4 cycles after request, one cycle wide.
REQ-031 Read address 0x0000_0040 -> pmem_rdata = all 0xA5 bytes in resp cycle, held afterwards; read 0x0000_005F -> same line returned (offset ignored).
REQ-032 IDX_BITS=8: write 0x11..11 to 0x0000_0000, read 0x0000_2000 -> 0x11..11 (alias).
REQ-033 Assert rst in BUSY of a write of 0xFF..FF to 0x80 holding old 0x00..00 -> no pmem_resp; subsequent read of 0x80 returns 0x00..00.
REQ-034 Checker build: read and write both high -> write performed, pmem_err=1 and stays 1 until rst; non-checker build -> pmem_err=0 throughout.
REQ-035 LATENCY=1: back-to-back write then read of same line with request held -> resp in cycles t+1 and t+3, read data equals written data.
